// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RISC-V core.
//
// Takes the ALU result, store data and load/store control from execute and
// runs one request/acknowledge transaction at a time on the data-memory port.
// It aligns, masks and sign-extends load data, then registers the result into
// the writeback bundle. stall_o holds upstream while a transaction is open.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   valid_i, mem_read_i, mem_write_i, funct3_i, alu_result_i,
//   mem_write_data_i, reg_write_i, rd_addr_i      execute-stage inputs
//   stall_o                     combinational upstream hold
//   dmem_req_o/we_o/addr_o/be_o/wdata_o, dmem_ack_i, dmem_rdata_i
//                               data-memory port (word addressed, byte lanes)
//   wb_valid_o, wb_reg_write_o, wb_rd_addr_o, wb_data_o   registered writeback
//   misalign_o                  registered one-cycle misaligned-access flag
//
// Build option
//   MEM_MISALIGN_TRAP_EN  defined: misaligned H/W accesses are dropped and
//                         flagged on misalign_o. Undefined: the address is
//                         forced to natural alignment and misalign_o is 0.

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] mem_write_data_i,
    input  logic        reg_write_i,
    input  logic [4:0]  rd_addr_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_reg_write_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o
);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic       mem_op;
    logic       is_b, is_h;
    logic       trap;
    logic [1:0] off;
    logic [3:0] be;
    logic [31:0] wdata;

    // Latched transaction context, used when the ack arrives
    logic       lat_reg_write;
    logic [4:0] lat_rd;
    logic [2:0] lat_funct3;
    logic [1:0] lat_off;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign mem_op = valid_i && (mem_read_i || mem_write_i);
    assign is_b   = (funct3_i == 3'b000) || (funct3_i == 3'b100);
    assign is_h   = (funct3_i == 3'b001) || (funct3_i == 3'b101);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_h && alu_result_i[0]) ||
                        (!is_b && !is_h && (alu_result_i[1:0] != 2'b00));
    assign trap = mem_op && misaligned;
`else
    assign trap = 1'b0;
`endif

    // Byte offset after natural alignment: H keeps bit 1, W keeps neither.
    // With the trap enabled a misaligned access never reaches the port, so
    // the same forcing is harmless there.
    assign off = is_b ? alu_result_i[1:0] :
                 is_h ? {alu_result_i[1], 1'b0} : 2'b00;

    always_comb begin
        be    = 4'b1111;
        wdata = mem_write_data_i;
        if (mem_write_i) begin
            if (is_b) begin
                be    = 4'b0001 << off;
                wdata = {4{mem_write_data_i[7:0]}};
            end else if (is_h) begin
                be    = 4'b0011 << off;
                wdata = {2{mem_write_data_i[15:0]}};
            end
        end
    end

    // Load extraction from the returned word using the latched offset
    always_comb begin
        byte_sel = 8'h00;
        case (lat_off)
            2'd0: byte_sel = dmem_rdata_i[7:0];
            2'd1: byte_sel = dmem_rdata_i[15:8];
            2'd2: byte_sel = dmem_rdata_i[23:16];
            2'd3: byte_sel = dmem_rdata_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lat_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (lat_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0000, half_sel};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !trap) begin
                    stall_o   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_o = !dmem_ack_i;
                if (dmem_ack_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req_o     <= 1'b0;
            dmem_we_o      <= 1'b0;
            dmem_addr_o    <= 32'h0;
            dmem_be_o      <= 4'h0;
            dmem_wdata_o   <= 32'h0;
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_addr_o   <= 5'h0;
            wb_data_o      <= 32'h0;
            lat_reg_write  <= 1'b0;
            lat_rd         <= 5'h0;
            lat_funct3     <= 3'h0;
            lat_off        <= 2'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap) begin
                        wb_valid_o     <= 1'b1;
                        wb_reg_write_o <= 1'b0;
                        wb_rd_addr_o   <= rd_addr_i;
                        wb_data_o      <= 32'h0;
                    end else if (mem_op) begin
                        dmem_req_o    <= 1'b1;
                        dmem_we_o     <= mem_write_i;
                        dmem_addr_o   <= {alu_result_i[31:2], 2'b00};
                        dmem_be_o     <= be;
                        dmem_wdata_o  <= wdata;
                        lat_reg_write <= reg_write_i;
                        lat_rd        <= rd_addr_i;
                        lat_funct3    <= funct3_i;
                        lat_off       <= off;
                        wb_valid_o    <= 1'b0;
                    end else if (valid_i) begin
                        wb_valid_o     <= 1'b1;
                        wb_reg_write_o <= reg_write_i;
                        wb_rd_addr_o   <= rd_addr_i;
                        wb_data_o      <= alu_result_i;
                    end else begin
                        wb_valid_o <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ack_i) begin
                        dmem_req_o     <= 1'b0;
                        wb_valid_o     <= 1'b1;
                        wb_reg_write_o <= lat_reg_write;
                        wb_rd_addr_o   <= lat_rd;
                        wb_data_o      <= dmem_we_o ? 32'h0 : load_data;
                    end else begin
                        wb_valid_o <= 1'b0;
                    end
                end
                default: wb_valid_o <= 1'b0;
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) misalign_o <= 1'b0;
        else     misalign_o <= (state == IDLE) && trap;
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule
